// File: rtl/dff_test_pkg.sv
// Shared types and helpers for the DFF radiation-test readout path.
package dff_test_pkg;

    localparam int N_BITS_DEF = 19;
    localparam int CNT_W_DEF  = 16;
    localparam int POP_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT
    } state_e;

    function automatic logic [7:0] popcount(input logic [POP_W-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < POP_W; i++) begin
            c = c + 8'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a one-cycle rising-edge pulse per bit.
module sync_edge #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]             prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/dff_scan_readout_ctrl.sv
// Snapshots the DFF chain on a Pi save request, counts upsets against the
// expected pattern and shifts the snapshot out MSB first on the Pi data clock.
module dff_scan_readout_ctrl
    import dff_test_pkg::*;
#(
    parameter int N_BITS      = N_BITS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              CLK_50M,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] dff_q,
    input  logic [N_BITS-1:0] expected,
    input  logic              save_data_dff_pi,
    input  logic              data_clk_dff_pi,
    input  logic              clr_cnt,
    output logic              data_out_dff_pi,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  upset_cnt,
    output logic              overrun
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SUM_W = CNT_W + 9;

    logic              save_rise, dclk_rise;
    logic              save_lvl_unused, dclk_lvl_unused;
    logic [N_BITS-1:0] dff_sync, dff_rise_unused;

    sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_save (
        .clk(CLK_50M), .rst_n(rst_n), .d(save_data_dff_pi),
        .q(save_lvl_unused), .rise(save_rise)
    );

    sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_dclk (
        .clk(CLK_50M), .rst_n(rst_n), .d(data_clk_dff_pi),
        .q(dclk_lvl_unused), .rise(dclk_rise)
    );

    sync_edge #(.W(N_BITS), .STAGES(SYNC_STAGES)) u_sync_dff (
        .clk(CLK_50M), .rst_n(rst_n), .d(dff_q),
        .q(dff_sync), .rise(dff_rise_unused)
    );

    state_e            state_q, state_d;
    logic [N_BITS-1:0] snap_q, snap_d;
    logic [N_BITS-1:0] mism_q, mism_d;
    logic              add_pend_q, add_pend_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  upset_cnt_q, upset_cnt_d;
    logic              overrun_q, overrun_d;
    logic [SUM_W-1:0]  upset_sum;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        mism_d      = mism_q;
        add_pend_d  = 1'b0;
        bit_idx_d   = bit_idx_q;
        frame_cnt_d = frame_cnt_q;
        upset_cnt_d = upset_cnt_q;
        overrun_d   = overrun_q;
        upset_sum   = SUM_W'(upset_cnt_q) + SUM_W'(popcount(POP_W'(mism_q)));

        // A data clock edge coinciding with the save rise in IDLE is dropped.
        case (state_q)
            IDLE: begin
                if (save_rise) begin
                    state_d   = CAPTURE;
                    bit_idx_d = '0;
                end
            end
            CAPTURE: begin
                snap_d     = dff_sync;
                mism_d     = dff_sync ^ expected;
                add_pend_d = 1'b1;
                state_d    = SHIFT;
                if (save_rise) overrun_d = 1'b1;
            end
            SHIFT: begin
                if (save_rise) overrun_d = 1'b1;
                if (dclk_rise) begin
                    if (bit_idx_q == IDX_W'(N_BITS - 1)) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (add_pend_q) begin
            upset_cnt_d = (|upset_sum[SUM_W-1:CNT_W]) ? '1 : upset_sum[CNT_W-1:0];
        end

        if (clr_cnt) begin
            frame_cnt_d = '0;
            upset_cnt_d = '0;
            overrun_d   = 1'b0;
        end

        // Outputs are registered from next-state values so they line up with the state.
        data_out_d = (state_d == SHIFT) ? snap_d[IDX_W'(N_BITS - 1) - bit_idx_d] : 1'b0;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            mism_q      <= '0;
            add_pend_q  <= 1'b0;
            bit_idx_q   <= '0;
            data_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            upset_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            mism_q      <= mism_d;
            add_pend_q  <= add_pend_d;
            bit_idx_q   <= bit_idx_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            upset_cnt_q <= upset_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out_dff_pi = data_out_q;
    assign busy            = busy_q;
    assign frame_cnt       = frame_cnt_q;
    assign upset_cnt       = upset_cnt_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_dff_scan_readout_ctrl.sv
// Bench for dff_scan_readout_ctrl: Pi-style frames against a counting model.
module tb_dff_scan_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] dff_q, expected;
    logic        save, dclk, clr;
    logic        data_out, busy, overrun;
    logic [15:0] frame_cnt, upset_cnt;

    int   errors = 0;
    int   checks = 0;
    int   m_frames, m_upsets;
    logic m_ovr;

    always #10 clk = ~clk;

    dff_scan_readout_ctrl dut (
        .CLK_50M(clk), .rst_n(rst_n), .dff_q(dff_q), .expected(expected),
        .save_data_dff_pi(save), .data_clk_dff_pi(dclk), .clr_cnt(clr),
        .data_out_dff_pi(data_out), .busy(busy), .frame_cnt(frame_cnt),
        .upset_cnt(upset_cnt), .overrun(overrun)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_clear();
        m_frames = 0;
        m_upsets = 0;
        m_ovr    = 1'b0;
    endfunction

    function automatic void model_frame(input logic [18:0] d, input logic [18:0] e);
        m_upsets = m_upsets + $countones(d ^ e);
        if (m_upsets > 65535) m_upsets = 65535;
        if (m_frames < 65535) m_frames = m_frames + 1;
    endfunction

    task automatic start_frame(input logic [18:0] d, input logic [18:0] e);
        dff_q    = d;
        expected = e;
        cyc(4);
        save = 1'b1;
        cyc(6);
    endtask

    task automatic end_frame();
        save = 1'b0;
        cyc(4);
    endtask

    // Pi behaviour: sample, then a high phase and a low phase of 5 cycles each.
    task automatic read_frame(input logic [18:0] v, input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            checks++;
            if (data_out !== v[18-i]) begin
                errors++;
                $display("FAIL %s bit%0d: got %b want %b", tag, i, data_out, v[18-i]);
            end
            dclk = 1'b1;
            cyc(5);
            dclk = 1'b0;
            cyc(5);
        end
    endtask

    task automatic test_reset();
        logic [18:0] d;
        rst_n = 1'b0;
        cyc(3);
        checks++;
        if ({data_out, busy, overrun, frame_cnt, upset_cnt} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got do=%b busy=%b ovr=%b fc=%h uc=%h want all 0",
                     data_out, busy, overrun, frame_cnt, upset_cnt);
        end
        rst_n = 1'b1;
        cyc(3);
        d = 19'($urandom);
        start_frame(d, 19'($urandom));
        read_frame(d, 0, 4, "reset_pre");
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_shift: got do=%b busy=%b fc=%h want 0 0 0", data_out, busy, frame_cnt);
        end
        model_clear();
        save = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        d = 19'($urandom);
        start_frame(d, ~d);
        read_frame(d, 0, 18, "reset_post");
        end_frame();
        model_frame(d, ~d);
        checks++;
        if (frame_cnt !== 16'(m_frames) || upset_cnt !== 16'(m_upsets)) begin
            errors++;
            $display("FAIL reset_post_cnt: got fc=%0d uc=%0d want %0d %0d", frame_cnt, upset_cnt, m_frames, m_upsets);
        end
    endtask

    task automatic test_clean_frame();
        logic [18:0] stream;
        stream = 19'b1011010010110100101;
        start_frame(19'h5A5A5, 19'h5A5A5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_busy_on: got %b want 1", busy);
        end
        read_frame(stream, 0, 18, "clean");
        checks++;
        if (busy !== 1'b0 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL clean_busy_off: got busy=%b do=%b want 0 0", busy, data_out);
        end
        end_frame();
        model_frame(19'h5A5A5, 19'h5A5A5);
        checks++;
        if (frame_cnt !== 16'(m_frames) || upset_cnt !== 16'(m_upsets)) begin
            errors++;
            $display("FAIL clean_cnt: got fc=%0d uc=%0d want %0d %0d", frame_cnt, upset_cnt, m_frames, m_upsets);
        end
    endtask

    task automatic test_upsets();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        model_clear();
        start_frame(19'h00013, 19'h00000);
        read_frame(19'h00013, 0, 18, "upset1");
        end_frame();
        model_frame(19'h00013, 19'h00000);
        checks++;
        if (upset_cnt !== 16'(m_upsets) || upset_cnt !== 16'd3) begin
            errors++;
            $display("FAIL upset_first: got %0d want 3", upset_cnt);
        end
        start_frame(19'h7FFFF, 19'h00000);
        read_frame(19'h7FFFF, 0, 18, "upset2");
        end_frame();
        model_frame(19'h7FFFF, 19'h00000);
        checks++;
        if (upset_cnt !== 16'(m_upsets) || frame_cnt !== 16'(m_frames)) begin
            errors++;
            $display("FAIL upset_second: got uc=%0d fc=%0d want %0d %0d", upset_cnt, frame_cnt, m_upsets, m_frames);
        end
    endtask

    task automatic test_overrun();
        logic [18:0] d;
        d = 19'($urandom);
        start_frame(d, 19'($urandom));
        read_frame(d, 0, 6, "ovr_a");
        save = 1'b0;
        cyc(5);
        save = 1'b1;
        cyc(5);
        m_ovr = 1'b1;
        checks++;
        if (overrun !== m_ovr) begin
            errors++;
            $display("FAIL overrun_set: got %b want %b", overrun, m_ovr);
        end
        read_frame(d, 7, 18, "ovr_b");
        end_frame();
        model_frame(d, expected);
        checks++;
        if (frame_cnt !== 16'(m_frames) || upset_cnt !== 16'(m_upsets) || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_frame: got fc=%0d uc=%0d busy=%b want %0d %0d 0",
                     frame_cnt, upset_cnt, busy, m_frames, m_upsets);
        end
    endtask

    task automatic test_collision();
        logic [18:0] d;
        d        = 19'($urandom);
        dff_q    = d;
        expected = 19'($urandom);
        cyc(4);
        save = 1'b1;
        dclk = 1'b1;
        cyc(6);
        dclk = 1'b0;
        cyc(5);
        read_frame(d, 0, 18, "collision");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL collision_end: got busy=%b want 0", busy);
        end
        end_frame();
        model_frame(d, expected);
        checks++;
        if (frame_cnt !== 16'(m_frames) || upset_cnt !== 16'(m_upsets)) begin
            errors++;
            $display("FAIL collision_cnt: got fc=%0d uc=%0d want %0d %0d", frame_cnt, upset_cnt, m_frames, m_upsets);
        end
    endtask

    task automatic test_idle_clocks();
        dff_q = 19'h7FFFF;
        cyc(4);
        read_frame(19'h00000, 0, 9, "idle");
        checks++;
        if (frame_cnt !== 16'(m_frames) || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_cnt: got fc=%0d busy=%b want %0d 0", frame_cnt, busy, m_frames);
        end
    endtask

    task automatic test_random();
        logic [18:0] d, e;
        for (int f = 0; f < 4; f++) begin
            d = 19'($urandom);
            e = 19'($urandom);
            start_frame(d, e);
            read_frame(d, 0, 18, "random");
            end_frame();
            model_frame(d, e);
            checks++;
            if (frame_cnt !== 16'(m_frames) || upset_cnt !== 16'(m_upsets) || overrun !== m_ovr) begin
                errors++;
                $display("FAIL random_cnt%0d: got fc=%0d uc=%0d ovr=%b want %0d %0d %b",
                         f, frame_cnt, upset_cnt, overrun, m_frames, m_upsets, m_ovr);
            end
        end
    endtask

    task automatic test_saturation();
        logic [18:0] e;
        force dut.upset_cnt_q = 16'hFFFE;
        cyc(1);
        release dut.upset_cnt_q;
        cyc(1);
        m_upsets = 32'hFFFE;
        e = 19'($urandom);
        start_frame(e ^ 19'h41111, e);
        read_frame(e ^ 19'h41111, 0, 18, "sat1");
        end_frame();
        model_frame(e ^ 19'h41111, e);
        checks++;
        if (upset_cnt !== 16'(m_upsets) || upset_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_first: got %h want ffff", upset_cnt);
        end
        start_frame(~e, e);
        read_frame(~e, 0, 18, "sat2");
        end_frame();
        model_frame(~e, e);
        checks++;
        if (upset_cnt !== 16'(m_upsets)) begin
            errors++;
            $display("FAIL sat_hold: got %h want %h", upset_cnt, 16'(m_upsets));
        end
    endtask

    task automatic test_clr_coincident();
        logic [18:0] d;
        d = 19'($urandom);
        start_frame(d, ~d);
        read_frame(d, 0, 17, "clr_frame");
        checks++;
        if (data_out !== d[0] || busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_last_bit: got do=%b busy=%b want %b 1", data_out, busy, d[0]);
        end
        // The final rise reaches the controller two flops later; line clr up with it.
        dclk = 1'b1;
        cyc(2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(3);
        dclk = 1'b0;
        cyc(5);
        model_clear();
        checks++;
        if (frame_cnt !== 16'(m_frames) || upset_cnt !== 16'(m_upsets) || overrun !== m_ovr || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_coincident: got fc=%0d uc=%0d ovr=%b busy=%b want 0 0 0 0",
                     frame_cnt, upset_cnt, overrun, busy);
        end
        end_frame();
    endtask

    initial begin
        rst_n    = 1'b0;
        dff_q    = '0;
        expected = '0;
        save     = 1'b0;
        dclk     = 1'b0;
        clr      = 1'b0;
        model_clear();
        test_reset();
        test_clean_frame();
        test_upsets();
        test_overrun();
        test_collision();
        test_idle_clocks();
        test_random();
        test_saturation();
        test_clr_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_scan_readout_ctrl.md
# dff_scan_readout_ctrl

Sequences the radiation-test readout of the 19 DFF chain outputs (Q0_1…Q1_9) to the Raspberry Pi. When the Pi requests a save, the block snapshots the synchronized DFF outputs and counts upsets against an expected pattern. It then shifts the snapshot out serially on the Pi-driven data clock. It sits between the DFF pad inputs and the Pi GPIO pins in the DFF test top level, and is the only driver of the Pi data line.

## Interface
Parameters:
- N_BITS, 19, number of DFF outputs captured and shifted per frame
- SYNC_STAGES, 2, synchronizer depth for all asynchronous inputs (≥2)
- CNT_W, 16, width of the frame and upset counters

Ports:
- CLK_50M  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- dff_q  in  N_BITS  DFF outputs; bit 18 = Q0_1 … bit 0 = Q1_9; asynchronous
- expected  in  N_BITS  expected DFF pattern; static during a frame
- save_data_dff_pi  in  1  Pi save request; asynchronous, level
- data_clk_dff_pi  in  1  Pi shift clock; asynchronous
- clr_cnt  in  1  synchronous clear of counters and overrun; single-cycle pulse
- data_out_dff_pi  out  1  serial data to the Pi
- busy  out  1  high while in CAPTURE or SHIFT
- frame_cnt  out  CNT_W  completed frames, saturating
- upset_cnt  out  CNT_W  accumulated mismatching bits, saturating
- overrun  out  1  sticky: save request rose while busy

## Operation
- save_data_dff_pi, data_clk_dff_pi and every dff_q bit pass through SYNC_STAGES flops. Save and clock are rising-edge detected after synchronization.
- Reset values of all outputs and internal registers are 0. State is IDLE.
- FSM states:
  - **IDLE**
    - save rise → CAPTURE.
    - data_clk edges are ignored; data_out = 0.
  - **CAPTURE** (1 cycle)
    - snap ← synced dff_q.
    - mism ← snap XOR expected.
    - Go to SHIFT.
  - **SHIFT**
    - data_out = snap[N_BITS-1-bit_idx].
    - Each data_clk rise increments bit_idx (width ceil(log2 N_BITS)).
    - On the rise with bit_idx = N_BITS-1: frame_cnt += 1 (saturating at 2^CNT_W−1), then → IDLE, data_out = 0.
- Upset counting: popcount(mism) is added to upset_cnt one cycle after CAPTURE. The sum saturates at 2^CNT_W−1 and never wraps.
- A save rise in CAPTURE or SHIFT is ignored and sets overrun. The frame in progress is unaffected.
- Simultaneous save rise and data_clk rise in IDLE: the save wins and the clock edge is dropped.
- clr_cnt zeroes frame_cnt, upset_cnt and overrun. If a counter increment occurs in the same cycle, the clear wins. The FSM is unaffected.
- Reset mid-SHIFT: all state returns to IDLE at once and the partial frame is not counted.
- The save level is held high through a frame; a new frame requires the save line to go low and then high again.

## Timing
- The save rise on the pin is detected at cycle SYNC_STAGES+1. CAPTURE follows at the next cycle. data_out is valid with snap[18] 1 cycle after CAPTURE, i.e. ≤ SYNC_STAGES+3 cycles (≤100 ns) after the pin edge.
- After a data_clk pin rise, data_out updates within SYNC_STAGES+2 cycles (80 ns).
- Pi contract:
  - data_clk high and low times must each be ≥ SYNC_STAGES+2 cycles.
  - The Pi samples data_out before driving each rising edge, so it samples N_BITS bits MSB first.
  - The Pi waits ≥100 ns after the save rise before its first read.
- busy asserts in the CAPTURE cycle and deasserts in the cycle the FSM returns to IDLE.
- upset_cnt is valid 2 cycles after CAPTURE.

## Structure
- Shared package dff_test_pkg:
  - N_BITS_DEF = 19, CNT_W_DEF = 16.
  - FSM state typedef {IDLE, CAPTURE, SHIFT}.
  - popcount function.
- Sub-module sync_edge: SYNC_STAGES synchronizer plus rising-edge pulse output, parameterized width. Instantiated once for save, once for data_clk, and as a plain vector synchronizer for dff_q with its edge output unused.
- Counters and FSM live in the top controller.

## Test plan
- Reset: rst_n low mid-SHIFT after 5 clocks → data_out=0, busy=0, frame_cnt unchanged, IDLE. The next save starts a clean frame.
- Clean frame: dff_q = expected = 19'h5A5A5, save rise, 19 data_clk pulses → serial stream 1011010010110100101 (MSB first), frame_cnt=1, upset_cnt=0, busy drops after the 19th rise.
- Upsets: expected=19'h00000, dff_q=19'h00013 → upset_cnt=3. A second frame with dff_q=19'h7FFFF → upset_cnt=22, frame_cnt=2.
- Overrun and collision:
  - Save rise pulsed again during SHIFT → overrun=1, and the 19-bit stream is unchanged.
  - Save and data_clk rising in the same IDLE cycle → frame starts and bit_idx=0.
- Saturation and clear:
  - Preload upset_cnt=16'hFFFE, then a frame with 5 mismatches → 16'hFFFF.
  - clr_cnt coincident with a frame-completing edge → frame_cnt=0.
- Idle clocks: 10 data_clk pulses in IDLE → data_out stays 0, frame_cnt unchanged.
